reg_pipe: RTL and testbench

Parametrised elastic pipeline register for the DSP48A1 datapath. It generalises the single-stage register/bypass mux to DEPTH stages, with per-stage valid tracking, a valid/ready handshake with bubble collapse, a global clock enable and a synchronous flush. It sits on operand and result paths (A, B, C, D, M, P) wherever the multi-cycle pipeline must tolerate downstream stalls without dropping samples.

---
 rtl/dsp_pipe_pkg.sv | 22 ++
 rtl/pipe_stage.sv | 33 +++
 rtl/reg_pipe.sv | 116 +++++++++++
 tb/tb_reg_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pipe_pkg.sv
// Shared definitions for the elastic pipeline registers on the DSP datapath.
//   MAX_DEPTH : deepest legal pipe
//   cnt_w()   : width of the occupancy counter for a given depth
//   hs_t      : valid/ready handshake pair
package dsp_pipe_pkg;

  localparam int unsigned MAX_DEPTH = 8;

  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // Bits needed to hold 0..depth, never less than one.
  function automatic int unsigned cnt_w(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) <= depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data word.
//   clk      : rising-edge clock
//   clear    : synchronous clear of the valid bit (and data when CLEAR_DATA)
//   load     : capture the upstream valid/data this edge
//   up_valid : upstream valid bit
//   up_data  : upstream data word
//   valid    : stage holds a sample
//   data     : stage data word
module pipe_stage #(
  parameter int unsigned WIDTH      = 18,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Data only moves when a real sample arrives, so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= 1'b0;
      if (CLEAR_DATA) data <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake and
// bubble collapse; DEPTH=0 is a combinational passthrough.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : global clock enable, 0 freezes every stage
//   flush      : synchronous drop of all in-flight samples
//   in_valid   : upstream sample present
//   in_ready   : stage 0 accepts this cycle (combinational on out_ready)
//   D          : input data
//   out_valid  : last stage holds a sample
//   out_ready  : downstream accepts this cycle
//   out        : last stage data
//   count      : number of occupied stages
module reg_pipe
  import dsp_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned DEPTH      = 2,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          D,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);

  if (DEPTH > MAX_DEPTH) begin : g_depth_check
    $error("reg_pipe: DEPTH exceeds MAX_DEPTH");
  end

  if (DEPTH == 0) begin : g_bypass
    // Pure wires; control inputs have no effect without registers.
    assign out       = D;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign count     = '0;

    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, enable, flush};
  end else begin : g_pipe
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   r;
    logic             clear;
    logic             accept;
    logic             emit;
    logic [CW-1:0]    cnt_q;
    hs_t              out_hs;

    assign out_hs = '{valid: v[DEPTH-1], ready: out_ready};
    assign clear  = rst || flush;

    // Ready ripples back from the output; any empty stage opens the path behind it.
    always_comb begin
      r        = '0;
      r[DEPTH] = out_hs.ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        r[i] = !v[i] || r[i+1];
      end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
      logic             up_v;
      logic [WIDTH-1:0] up_d;

      if (i == 0) begin : g_head
        assign up_v = in_valid;
        assign up_d = D;
      end else begin : g_link
        assign up_v = v[i-1];
        assign up_d = d[i-1];
      end

      pipe_stage #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_stage (
        .clk      (clk),
        .clear    (clear),
        .load     (enable && r[i]),
        .up_valid (up_v),
        .up_data  (up_d),
        .valid    (v[i]),
        .data     (d[i])
      );
    end

    assign in_ready = r[0] && enable && !flush;
    assign accept   = in_valid && in_ready;
    assign emit     = out_hs.valid && out_hs.ready && enable;

    // Occupancy tracks transfers at both ends; flush/reset override.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        cnt_q <= '0;
      end else if (accept && !emit) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (emit && !accept) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end

    assign count     = cnt_q;
    assign out       = d[DEPTH-1];
    assign out_valid = out_hs.valid;
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe at depths 0, 2, 3 and 4 sharing one input bus.
module tb_reg_pipe;

  localparam int unsigned W = 18;

  logic         clk = 1'b0;
  logic         rst, enable, flush, in_valid, out_ready;
  logic [W-1:0] D;

  logic rdy0, ov0, rdy2, ov2, rdy3, ov3, rdy4, ov4;
  logic [W-1:0] o0, o2, o3, o4;
  logic [0:0] cnt0;
  logic [1:0] cnt2, cnt3;
  logic [2:0] cnt4;

  int checks   = 0;
  int failures = 0;
  int sel      = 2;

  logic         m_rdy, m_ov;
  logic [W-1:0] m_out;
  int           m_cnt;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(W), .DEPTH(0), .CLEAR_DATA(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy0), .D(D), .out_valid(ov0), .out_ready(out_ready), .out(o0), .count(cnt0));
  reg_pipe #(.WIDTH(W), .DEPTH(2), .CLEAR_DATA(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy2), .D(D), .out_valid(ov2), .out_ready(out_ready), .out(o2), .count(cnt2));
  reg_pipe #(.WIDTH(W), .DEPTH(3), .CLEAR_DATA(1'b1)) u_d3 (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy3), .D(D), .out_valid(ov3), .out_ready(out_ready), .out(o3), .count(cnt3));
  reg_pipe #(.WIDTH(W), .DEPTH(4), .CLEAR_DATA(1'b1)) u_d4 (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy4), .D(D), .out_valid(ov4), .out_ready(out_ready), .out(o4), .count(cnt4));

  // Route the instance under test onto one set of observation signals.
  always_comb begin
    m_rdy = rdy2; m_ov = ov2; m_out = o2; m_cnt = 32'(cnt2);
    case (sel)
      0: begin m_rdy = rdy0; m_ov = ov0; m_out = o0; m_cnt = 32'(cnt0); end
      3: begin m_rdy = rdy3; m_ov = ov3; m_out = o3; m_cnt = 32'(cnt3); end
      4: begin m_rdy = rdy4; m_ov = ov4; m_out = o4; m_cnt = 32'(cnt4); end
      default: ;
    endcase
  end

  // One clock of stimulus; returns what the handshake looked like before the edge.
  task automatic drive(input logic v, input logic [W-1:0] dd, input logic ordy,
                       input logic en, input logic fl,
                       output logic acc, output logic emi, output logic [W-1:0] eo,
                       output logic rdy);
    in_valid = v; D = dd; out_ready = ordy; enable = en; flush = fl;
    #1;
    rdy = m_rdy;
    acc = v && m_rdy;
    emi = m_ov && ordy && en && !fl;
    eo  = m_out;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; enable = 1'b1; flush = 1'b0; D = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 2;
    rst = 1'b1; in_valid = 1'b1; D = 18'h3FFFF; out_ready = 1'b1; enable = 1'b1; flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov2); end
      checks++; if (o2 !== '0) begin failures++; $display("FAIL reset_out got=%0h exp=0", o2); end
      checks++; if (cnt2 !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt2); end
      checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL reset_count_d4 got=%0d exp=0", cnt4); end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", rdy2); end
  endtask

  task automatic test_stream();
    logic acc, emi, rdy;
    logic [W-1:0] eo;
    sel = 2;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      drive(c < 10, W'(c + 1), 1'b1, 1'b1, 1'b0, acc, emi, eo, rdy);
      checks++;
      if (acc !== (c < 10)) begin failures++; $display("FAIL stream_accept cyc=%0d got=%b", c, acc); end
      checks++;
      if (emi !== (c >= 2 && c <= 11)) begin failures++; $display("FAIL stream_emit cyc=%0d got=%b", c, emi); end
      if (c >= 2 && c <= 11) begin
        checks++;
        if (eo !== W'(c - 1)) begin failures++; $display("FAIL stream_data cyc=%0d got=%0d exp=%0d", c, eo, c - 1); end
      end
      if (c >= 1 && c <= 9) begin
        checks++;
        if (m_cnt != 2) begin failures++; $display("FAIL stream_count cyc=%0d got=%0d exp=2", c, m_cnt); end
      end
    end
  endtask

  task automatic test_stall();
    logic acc, emi, rdy;
    logic [W-1:0] eo;
    sel = 2;
    apply_reset();
    drive(1'b1, W'(5), 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL stall_acc5 got=%b exp=1", acc); end
    drive(1'b1, W'(6), 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL stall_acc6 got=%b exp=1", acc); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(99), 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", rdy); end
      checks++; if (m_cnt != 2) begin failures++; $display("FAIL stall_count got=%0d exp=2", m_cnt); end
      checks++;
      if (m_ov !== 1'b1 || m_out !== W'(5)) begin
        failures++; $display("FAIL stall_hold got=%b/%0d exp=1/5", m_ov, m_out);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, acc, emi, eo, rdy);
      checks++;
      if (emi !== (c < 2)) begin failures++; $display("FAIL stall_emit cyc=%0d got=%b", c, emi); end
      if (c < 2) begin
        checks++;
        if (eo !== W'(5 + c)) begin failures++; $display("FAIL stall_drain cyc=%0d got=%0d exp=%0d", c, eo, 5 + c); end
      end
    end
  endtask

  task automatic test_bubble();
    logic acc, emi, rdy;
    logic [W-1:0] eo;
    logic [W-1:0] vals [4];
    logic [W-1:0] got [$];
    sel = 4;
    apply_reset();
    for (int i = 0; i < 4; i++) vals[i] = W'($urandom);
    drive(1'b1, vals[0], 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bubble_acc_a got=%b", acc); end
    for (int i = 0; i < 2; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bubble_acc idx=%0d got=%b", i, acc); end
    end
    checks++; if (m_cnt != 4) begin failures++; $display("FAIL bubble_count got=%0d exp=4", m_cnt); end
    drive(1'b1, W'($urandom), 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL bubble_full_ready got=%b exp=0", rdy); end
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, acc, emi, eo, rdy);
      if (emi) got.push_back(eo);
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL bubble_emit_count got=%0d exp=4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== vals[i]) begin failures++; $display("FAIL bubble_order idx=%0d got=%0h exp=%0h", i, got[i], vals[i]); end
      end
    end
  endtask

  task automatic test_flush_enable();
    logic acc, emi, rdy;
    logic [W-1:0] eo, x, y;
    logic [W-1:0] got [$];
    sel = 3;
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, W'($urandom_range(100, 5000)), 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    checks++; if (m_cnt != 3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", m_cnt); end
    drive(1'b1, W'(7), 1'b0, 1'b1, 1'b1, acc, emi, eo, rdy);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", rdy); end
    checks++; if (m_cnt != 0) begin failures++; $display("FAIL flush_count got=%0d exp=0", m_cnt); end
    checks++; if (m_ov !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", m_ov); end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, acc, emi, eo, rdy);
      checks++; if (emi !== 1'b0) begin failures++; $display("FAIL flush_ghost cyc=%0d got=%0h", c, eo); end
    end
    x = W'($urandom); y = W'($urandom);
    drive(1'b1, x, 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    drive(1'b1, y, 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc, emi, eo, rdy);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'($urandom), 1'b1, 1'b0, 1'b0, acc, emi, eo, rdy);
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL enable_in_ready cyc=%0d got=%b exp=0", c, rdy); end
      checks++;
      if (m_ov !== 1'b1 || m_out !== x) begin
        failures++; $display("FAIL enable_hold cyc=%0d got=%b/%0h exp=1/%0h", c, m_ov, m_out, x);
      end
      checks++; if (m_cnt != 2) begin failures++; $display("FAIL enable_count cyc=%0d got=%0d exp=2", c, m_cnt); end
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, acc, emi, eo, rdy);
      if (emi) got.push_back(eo);
    end
    checks++;
    if (got.size() != 2 || got[0] !== x || got[1] !== y) begin
      failures++; $display("FAIL enable_drain got_n=%0d exp=2 (%0h,%0h)", got.size(), x, y);
    end
  endtask

  task automatic test_depth0();
    sel = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); enable = 1'($urandom);
      flush = 1'($urandom); D = W'($urandom);
      #1;
      checks++; if (m_out !== D) begin failures++; $display("FAIL d0_out got=%0h exp=%0h", m_out, D); end
      checks++; if (m_ov !== in_valid) begin failures++; $display("FAIL d0_valid got=%b exp=%b", m_ov, in_valid); end
      checks++; if (m_rdy !== out_ready) begin failures++; $display("FAIL d0_ready got=%b exp=%b", m_rdy, out_ready); end
      checks++; if (m_cnt != 0) begin failures++; $display("FAIL d0_count got=%0d exp=0", m_cnt); end
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard soak on DEPTH=3: the pipe is modelled as a FIFO of at most 3 samples.
  task automatic test_soak();
    logic [W-1:0] q [$];
    logic v, ordy, en, fl, exp_rdy, emit, acc;
    logic [W-1:0] dd;
    sel = 3;
    apply_reset();
    for (int c = 0; c < 1010; c++) begin
      if (c < 1000) begin
        v    = ($urandom % 4) != 0;
        ordy = ($urandom % 3) != 0;
        en   = ($urandom % 8) != 0;
        fl   = ($urandom % 64) == 0;
      end else begin
        v = 1'b0; ordy = 1'b1; en = 1'b1; fl = 1'b0;
      end
      dd = W'($urandom);
      in_valid = v; D = dd; out_ready = ordy; enable = en; flush = fl;
      #1;
      exp_rdy = en && !fl && (q.size() < 3 || ordy);
      checks++;
      if (m_rdy !== exp_rdy) begin failures++; $display("FAIL soak_in_ready cyc=%0d got=%b exp=%b", c, m_rdy, exp_rdy); end
      checks++;
      if (m_ov === 1'b1 && q.size() == 0) begin failures++; $display("FAIL soak_phantom cyc=%0d out=%0h", c, m_out); end
      emit = m_ov && ordy && en && !fl;
      if (emit && q.size() > 0) begin
        checks++;
        if (m_out !== q[0]) begin failures++; $display("FAIL soak_order cyc=%0d got=%0h exp=%0h", c, m_out, q[0]); end
        void'(q.pop_front());
      end
      acc = v && exp_rdy;
      if (fl) q.delete();
      else if (acc) q.push_back(dd);
      @(posedge clk); #1;
      checks++;
      if (m_cnt != q.size()) begin failures++; $display("FAIL soak_count cyc=%0d got=%0d exp=%0d", c, m_cnt, q.size()); end
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL soak_lost remaining=%0d exp=0", q.size()); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; D = '0;
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_flush_enable();
    test_depth0();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
